// File: rtl/systolic_pkg.sv
// Shared defaults and feeder state encoding for the systolic array, tpumac and operand feeders.
// No logic; a stream takes stream_steps(DIM) enabled edges.
package systolic_pkg;

    localparam int BITS_AB_DEF = 8;
    localparam int DIM_DEF     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    function automatic int stream_steps(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage

// File: rtl/skew_row.sv
// One operand row: DIM-entry parallel-load shift register feeding ROW+1 zero-reset output stages.
// Element k appears on dout ROW+1 shifts after it leaves the register; shift=0 freezes everything.
module skew_row
    import systolic_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DIM     = DIM_DEF,
    parameter int ROW     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          shift,
    input  logic [DIM-1:0][BITS_AB-1:0]   din,
    output logic [BITS_AB-1:0]            dout
);

    logic [DIM-1:0][BITS_AB-1:0] sh;
    // Stage 0 is the register the array sees for row 0; later stages add the skew.
    logic [ROW:0][BITS_AB-1:0]   chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh    <= '0;
            chain <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
            for (int i = 0; i < DIM - 1; i++) begin
                sh[i] <= sh[i+1];
            end
            sh[DIM-1] <= '0;
            chain[0]  <= sh[0];
            for (int j = 1; j <= ROW; j++) begin
                chain[j] <= chain[j-1];
            end
        end
    end

    assign dout = chain[ROW];

endmodule

// File: rtl/systolic_a_feeder.sv
// Holds a DIM x DIM A tile and streams it skewed into the array's left edge over 2*DIM-1 enabled edges.
// en=0 stalls the stream; WrEn/start are only honoured in IDLE.
module systolic_a_feeder
    import systolic_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int DIM     = DIM_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          WrEn,
    input  logic [$clog2(DIM)-1:0]        Crow,
    input  logic [DIM-1:0][BITS_AB-1:0]   Ain,
    input  logic                          start,
    output logic [DIM-1:0][BITS_AB-1:0]   Aout,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = $clog2(DIM);
    localparam int SW = $clog2(2 * DIM);
    localparam logic [SW-1:0] LAST_STEP = SW'(stream_steps(DIM) - 1);

    feeder_state_t   state;
    logic [SW-1:0]   step;
    logic            shift;
    logic [DIM-1:0]  load;

    assign shift = (state == STREAM) && en;

    // Out-of-range Crow matches no row, so the write is dropped.
    always_comb begin
        load = '0;
        if ((state == IDLE) && WrEn) begin
            for (int r = 0; r < DIM; r++) begin
                if (Crow == CW'(r)) begin
                    load[r] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        step  <= '0;
                        busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (en) begin
                        if (step == LAST_STEP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < DIM; r++) begin : g_row
        skew_row #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .ROW     (r)
        ) u_row (
            .clk   (clk),
            .rst   (rst),
            .load  (load[r]),
            .shift (shift),
            .din   (Ain),
            .dout  (Aout[r])
        );
    end

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Randomized and directed stimulus for systolic_a_feeder, checked by a queue-based scoreboard
// against a tile/step reference model.
module tb_systolic_a_feeder;

    localparam int BITS_AB = 8;
    localparam int DIM     = 8;
    localparam int NSTEPS  = 2 * DIM - 1;

    typedef logic [DIM-1:0][BITS_AB-1:0] vec_t;
    typedef struct {
        vec_t aout;
        logic busy;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       WrEn;
    logic [2:0] Crow;
    vec_t       Ain;
    logic       start;
    vec_t       Aout;
    logic       busy;
    logic       done;

    systolic_a_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .WrEn  (WrEn),
        .Crow  (Crow),
        .Ain   (Ain),
        .start (start),
        .Aout  (Aout),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    // Reference model: the loaded tile, the snapshot being streamed and the step index.
    vec_t mA[DIM];
    vec_t mT[DIM];
    vec_t m_aout;
    bit   m_stream;
    bit   m_done;
    int   m_k;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int c = 0; c < DIM; c++) v[c] = BITS_AB'($urandom);
        return v;
    endfunction

    function automatic vec_t seq_row(input int r);
        vec_t v;
        for (int c = 0; c < DIM; c++) v[c] = BITS_AB'(8 * r + c + 1);
        return v;
    endfunction

    task automatic model_edge();
        exp_t e;
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                mA[r] = '0;
                mT[r] = '0;
            end
            m_aout   = '0;
            m_stream = 0;
            m_done   = 0;
            m_k      = 0;
        end else begin
            m_done = 0;
            if (!m_stream) begin
                if (WrEn && int'(Crow) < DIM) mA[Crow] = Ain;
                if (start) begin
                    m_stream = 1;
                    m_k      = 0;
                    for (int r = 0; r < DIM; r++) begin
                        mT[r] = mA[r];
                        mA[r] = '0;
                    end
                end
            end else if (en) begin
                m_k++;
                for (int r = 0; r < DIM; r++) begin
                    int idx;
                    idx = m_k - 1 - r;
                    m_aout[r] = (idx >= 0 && idx < DIM) ? mT[r][idx] : '0;
                end
                if (m_k == NSTEPS) begin
                    m_stream = 0;
                    m_done   = 1;
                end
            end
        end
        e.aout = m_aout;
        e.busy = m_stream;
        e.done = m_done;
        sb.push_back(e);
    endtask

    // Drive one cycle's inputs, record the expected post-edge outputs, then step past the edge.
    task automatic cyc(input logic r_i, input logic en_i, input logic w_i,
                       input logic [2:0] cr_i, input vec_t a_i, input logic s_i);
        rst   = r_i;
        en    = en_i;
        WrEn  = w_i;
        Crow  = cr_i;
        Ain   = a_i;
        start = s_i;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0);
    endtask

    task automatic load_seq();
        for (int r = 0; r < DIM; r++) cyc(1'b0, 1'b0, 1'b1, 3'(r), seq_row(r), 1'b0);
    endtask

    task automatic start_cyc();
        cyc(1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b1);
    endtask

    task automatic step_cyc();
        cyc(1'b0, 1'b1, 1'b0, 3'd0, '0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_aout", Aout, e.aout);
            chk("sb_busy", {63'd0, busy}, {63'd0, e.busy});
            chk("sb_done", {63'd0, done}, {63'd0, e.done});
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; WrEn = 1'b0; Crow = '0; Ain = '0; start = 1'b0;

        // Reset with write and start active
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 3'd0, rand_vec(), 1'b1);
        chk("rst_aout", Aout, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        idle_cyc();

        // Basic stream
        load_seq();
        start_cyc();
        chk("t2_busy_start", {63'd0, busy}, 64'd1);
        for (int k = 1; k <= NSTEPS; k++) begin
            step_cyc();
            if (k == 1) begin
                chk("t2_s1_a0", Aout[0], 64'd1);
                chk("t2_s1_a1", Aout[1], 64'd0);
            end
            if (k == 8) begin
                chk("t2_s8_a0", Aout[0], 64'd8);
                chk("t2_s8_a7", Aout[7], 64'd57);
            end
            if (k == NSTEPS) begin
                chk("t2_s15_a7", Aout[7], 64'd64);
                chk("t2_s15_a6", Aout[6], 64'd0);
                chk("t2_done", {63'd0, done}, 64'd1);
                chk("t2_busy_end", {63'd0, busy}, 64'd0);
            end
        end
        idle_cyc();
        chk("t2_done_pulse", {63'd0, done}, 64'd0);
        chk("t2_hold_a7", Aout[7], 64'd64);

        // Stall for 3 cycles after step 4
        load_seq();
        start_cyc();
        for (int k = 1; k <= NSTEPS + 3; k++) begin
            cyc(1'b0, !(k >= 5 && k <= 7), 1'b0, 3'd0, '0, 1'b0);
            if (k == 7) begin
                chk("t3_stall_a0", Aout[0], 64'd4);
                chk("t3_stall_a3", Aout[3], 64'd25);
            end
            if (k == NSTEPS + 2) chk("t3_no_early_done", {63'd0, done}, 64'd0);
            if (k == NSTEPS + 3) chk("t3_done", {63'd0, done}, 64'd1);
        end

        // Negative data; noise on WrEn/start while streaming
        cyc(1'b0, 1'b0, 1'b1, 3'd0, vec_t'(64'h8786858483828180), 1'b0);
        for (int r = 1; r < DIM; r++) cyc(1'b0, 1'b0, 1'b1, 3'(r), seq_row(r), 1'b0);
        start_cyc();
        for (int k = 1; k <= NSTEPS; k++) begin
            cyc(1'b0, 1'b1, 1'($urandom), 3'($urandom), rand_vec(), 1'($urandom));
            if (k == 1) chk("t4_s1_a0", Aout[0], 64'h80);
            if (k == 8) chk("t4_s8_a0", Aout[0], 64'h87);
            if (k == NSTEPS) chk("t4_done", {63'd0, done}, 64'd1);
        end
        idle_cyc();

        // Reset mid-stream, then a zero stream without reload
        load_seq();
        start_cyc();
        repeat (5) step_cyc();
        cyc(1'b1, 1'b1, 1'b0, 3'd0, '0, 1'b0);
        chk("t5_rst_aout", Aout, 64'd0);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_done", {63'd0, done}, 64'd0);
        idle_cyc();
        start_cyc();
        for (int k = 1; k <= NSTEPS; k++) begin
            step_cyc();
            if (k == NSTEPS) chk("t5_zero_done", {63'd0, done}, 64'd1);
        end
        idle_cyc();

        // Write and start in the same cycle
        for (int r = 0; r < DIM; r++) cyc(1'b0, 1'b0, 1'b1, 3'(r), rand_vec(), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, vec_t'({DIM{8'h7F}}), 1'b1);
        for (int k = 1; k <= NSTEPS; k++) begin
            step_cyc();
            if (k == 3)  chk("t6_s3_a3", Aout[3], 64'd0);
            if (k == 4)  chk("t6_s4_a3", Aout[3], 64'h7F);
            if (k == 11) chk("t6_s11_a3", Aout[3], 64'h7F);
            if (k == 12) chk("t6_s12_a3", Aout[3], 64'd0);
        end
        idle_cyc();

        // Randomized streams with stalls, noise and occasional reset
        for (int it = 0; it < 8; it++) begin
            int nl;
            nl = $urandom_range(2, 12);
            for (int i = 0; i < nl; i++) cyc(1'b0, 1'($urandom), 1'b1, 3'($urandom), rand_vec(), 1'b0);
            start_cyc();
            for (int i = 0; i < 100 && m_stream; i++) begin
                cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7),
                    1'($urandom), 3'($urandom), rand_vec(), 1'($urandom));
            end
            if (m_stream) chk("rand_stream_bound", 64'd1, 64'd0);
            repeat (2) idle_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
